// File: rtl/spw_port_ingress.sv
// SpaceWire per-port ingress: buffers N-Chars, decodes the address byte, holds a matrix connection per packet.
// Latency: a char written in cycle t reaches the head in t+1; tx outputs are registered from next-state values.
// Backpressure: rx_ready deasserts when the FIFO is full; tx_ready low stalls forwarding with tx_char held stable.
// Optional grant-wait timeout compiled in with `define SPW_REQ_TIMEOUT_EN.

module spw_ingress_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic         gclk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] head,
    output logic         empty,
    output logic [W-1:0] nxt_head,
    output logic         nxt_empty,
    output logic         nxt_full
);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic         full, do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_comb begin
        wr_nxt = wr_ptr + (AW+1)'(do_push);
        rd_nxt = rd_ptr + (AW+1)'(do_pop);
        if (flush) begin
            wr_nxt = '0;
            rd_nxt = '0;
        end
    end

    assign nxt_empty = (wr_nxt == rd_nxt);
    assign nxt_full  = (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
    // The head one cycle ahead may be the char being written right now.
    assign nxt_head  = (do_push && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0])) ? push_dat
                                                                      : mem[rd_nxt[AW-1:0]];

    always_ff @(posedge gclk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
        end
    end

    always_ff @(posedge gclk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

module spw_port_ingress #(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int PORTNUM  = 8,
    parameter int LOG_PORT = 1,
    parameter int TIMEOUT  = 1024
) (
    input  logic       gclk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [8:0] rx_char,
    output logic       rx_ready,
    input  logic       link_err,
    output logic       req,
    output logic [4:0] req_port,
    input  logic       gnt,
    output logic       tx_valid,
    output logic [8:0] tx_char,
    input  logic       tx_ready,
    output logic       busy,
    output logic [7:0] drop_cnt
);
    typedef enum logic [2:0] {IDLE, REQ, XFER, EEP_INS, DISCARD} state_t;

    localparam logic [7:0] PMAX = PORTNUM[7:0];
    localparam logic [4:0] LOGP = LOG_PORT[4:0];
    localparam logic [8:0] EEP  = 9'h101;

    if (DEPTH != (1 << AW) || TIMEOUT < 1) begin : g_param_check
        $error("spw_port_ingress: DEPTH must equal 2**AW and TIMEOUT must be positive");
    end

    state_t     state, state_nxt;
    logic       push, pop, flush, drop_inc, port_ld;
    logic [4:0] port_val;
    logic [8:0] head, nxt_head;
    logic       empty, nxt_empty, nxt_full;

`ifdef SPW_REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
    logic [TW-1:0] tcnt;
    logic          tcnt_clr, tcnt_inc;
`endif

    assign push = rx_valid && rx_ready && !flush;

    spw_ingress_fifo #(.W(9), .DEPTH(DEPTH), .AW(AW)) u_fifo (
        .gclk      (gclk),
        .reset     (reset),
        .push      (push),
        .push_dat  (rx_char),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .empty     (empty),
        .nxt_head  (nxt_head),
        .nxt_empty (nxt_empty),
        .nxt_full  (nxt_full)
    );

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        flush     = 1'b0;
        drop_inc  = 1'b0;
        port_ld   = 1'b0;
        port_val  = '0;
`ifdef SPW_REQ_TIMEOUT_EN
        tcnt_clr  = 1'b0;
        tcnt_inc  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (link_err) begin
                    flush = 1'b1;
                end else if (!empty) begin
                    if (head[8]) begin
                        pop = 1'b1;
                    end else if (head[7:0] <= PMAX) begin
                        // Path address: the header is consumed here, never forwarded.
                        pop       = 1'b1;
                        port_ld   = 1'b1;
                        port_val  = head[4:0];
                        state_nxt = REQ;
`ifdef SPW_REQ_TIMEOUT_EN
                        tcnt_clr  = 1'b1;
`endif
                    end else if (head[7:0] >= 8'd32 && head[7:0] != 8'd255) begin
                        port_ld   = 1'b1;
                        port_val  = LOGP;
                        state_nxt = REQ;
`ifdef SPW_REQ_TIMEOUT_EN
                        tcnt_clr  = 1'b1;
`endif
                    end else begin
                        drop_inc  = 1'b1;
                        state_nxt = DISCARD;
                    end
                end
            end
            REQ: begin
                if (link_err) begin
                    flush     = 1'b1;
                    drop_inc  = 1'b1;
                    state_nxt = IDLE;
                end else if (gnt) begin
                    state_nxt = XFER;
`ifdef SPW_REQ_TIMEOUT_EN
                end else if (tcnt == TMAX) begin
                    drop_inc  = 1'b1;
                    state_nxt = DISCARD;
                end else begin
                    tcnt_inc  = 1'b1;
`endif
                end
            end
            XFER: begin
                if (link_err) begin
                    flush     = 1'b1;
                    state_nxt = EEP_INS;
                end else if (tx_valid && tx_ready) begin
                    pop = 1'b1;
                    if (tx_char[8]) state_nxt = IDLE;
                end
            end
            EEP_INS: begin
                if (tx_ready) state_nxt = IDLE;
            end
            DISCARD: begin
                if (link_err) begin
                    flush     = 1'b1;
                    state_nxt = IDLE;
                end else if (!empty) begin
                    pop = 1'b1;
                    if (head[8]) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge gclk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rx_ready <= 1'b0;
            req      <= 1'b0;
            req_port <= '0;
            tx_valid <= 1'b0;
            tx_char  <= '0;
            busy     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rx_ready <= !nxt_full;
            busy     <= (state_nxt != IDLE);
            // req follows the connection one cycle behind entry and drops as soon as it is released.
            req      <= ((state == REQ)  && (state_nxt == REQ || state_nxt == XFER)) ||
                        ((state == XFER) && (state_nxt == XFER));
            if (port_ld) req_port <= port_val;
            tx_valid <= ((state_nxt == XFER) && !nxt_empty) || (state_nxt == EEP_INS);
            if (state_nxt == EEP_INS)
                tx_char <= EEP;
            else if (state_nxt == XFER && !nxt_empty)
                tx_char <= nxt_head;
            if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

`ifdef SPW_REQ_TIMEOUT_EN
    always_ff @(posedge gclk or negedge reset) begin
        if (!reset)        tcnt <= '0;
        else if (tcnt_clr) tcnt <= '0;
        else if (tcnt_inc) tcnt <= tcnt + TW'(1);
    end
`endif
endmodule

// File: tb/tb_spw_port_ingress.sv
// Bench for spw_port_ingress: packet-level routing model with a per-cycle scoreboard on the tx side,
// plus literal expectations for each directed scenario.
module tb_spw_port_ingress;
    localparam int TO = 8;

    logic       gclk = 1'b0;
    logic       reset;
    logic       rx_valid, rx_ready, link_err, req, gnt, tx_valid, tx_ready, busy;
    logic [8:0] rx_char, tx_char;
    logic [4:0] req_port;
    logic [7:0] drop_cnt;

    spw_port_ingress #(.DEPTH(16), .AW(4), .PORTNUM(8), .LOG_PORT(1), .TIMEOUT(TO)) dut (
        .gclk     (gclk),
        .reset    (reset),
        .rx_valid (rx_valid),
        .rx_char  (rx_char),
        .rx_ready (rx_ready),
        .link_err (link_err),
        .req      (req),
        .req_port (req_port),
        .gnt      (gnt),
        .tx_valid (tx_valid),
        .tx_char  (tx_char),
        .tx_ready (tx_ready),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 gclk = ~gclk;

    int checks = 0;
    int failures = 0;

    logic [8:0] rx_q[$];
    logic [8:0] pkt[$];
    logic [8:0] exp_tx[$];
    logic [4:0] exp_port[$];
    logic [8:0] tx_log[$];
    int         drop_exp = 0;
    int         rx_acc_cnt = 0;
    int         req_rises = 0;
    int         req_hi_cnt = 0;
    int         last_port = -1;
    int         gnt_delay = 1;
    bit         gnt_en = 1'b1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Routing rules applied to a whole packet: which port, which chars come out, or a discard.
    task automatic send_pkt();
        logic [7:0] a;
        a = pkt[0][7:0];
        foreach (pkt[i]) rx_q.push_back(pkt[i]);
        if (a <= 8'd8) begin
            exp_port.push_back(a[4:0]);
            for (int i = 1; i < pkt.size(); i++) exp_tx.push_back(pkt[i]);
        end else if (a >= 8'd32 && a <= 8'd254) begin
            exp_port.push_back(5'd1);
            foreach (pkt[i]) exp_tx.push_back(pkt[i]);
        end else begin
            drop_exp = (drop_exp == 255) ? 255 : drop_exp + 1;
        end
    endtask

    task automatic wait_idle();
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < 3000) begin
            @(negedge gclk);
            n++;
            if (rx_q.size() == 0 && !rx_valid && !busy && exp_tx.size() == 0) quiet++;
            else quiet = 0;
        end
        if (quiet < 4) begin
            checks++;
            failures++;
            $display("FAIL idle_wait timed out busy=%0b pending_tx=%0d", busy, exp_tx.size());
        end
        chk("drop_cnt_model", drop_cnt, drop_exp);
        chk("ports_outstanding", exp_port.size(), 0);
    endtask

    // Codec side: offer the head of rx_q, advance on handshake.
    initial begin
        bit acc;
        rx_valid = 1'b0;
        rx_char  = '0;
        forever begin
            @(negedge gclk);
            acc = rx_valid && rx_ready && reset;
            @(posedge gclk);
            #1;
            if (acc) begin
                void'(rx_q.pop_front());
                rx_acc_cnt++;
            end
            if (rx_q.size() > 0) begin
                rx_valid = 1'b1;
                rx_char  = rx_q[0];
            end else begin
                rx_valid = 1'b0;
            end
        end
    end

    // Matrix grant: gnt_delay cycles after req, held while req stays high.
    initial begin
        int gcnt = 0;
        gnt = 1'b0;
        forever begin
            @(posedge gclk);
            #1;
            if (!req || !gnt_en) begin
                gnt  = 1'b0;
                gcnt = 0;
            end else if (gcnt >= gnt_delay) begin
                gnt = 1'b1;
            end else begin
                gcnt++;
            end
        end
    end

    // Scoreboard: every accepted tx char, every new request, stall stability, req release.
    logic       req_prev = 1'b0, prev_stall = 1'b0, lerr_prev = 1'b0, prev_ctrl_acc = 1'b0;
    logic [9:0] prev_vc = '0;
    always @(negedge gclk) begin
        if (reset) begin
            if (tx_valid && tx_ready) begin
                tx_log.push_back(tx_char);
                if (exp_tx.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected got=0x%0h exp=none", tx_char);
                end else begin
                    chk("tx_char", tx_char, exp_tx.pop_front());
                end
            end
            if (prev_stall && !lerr_prev) chk("tx_hold", {tx_valid, tx_char}, prev_vc);
            if (prev_ctrl_acc) chk("req_after_end", req, 1'b0);
            if (req && !req_prev) begin
                req_rises++;
                last_port = req_port;
                if (exp_port.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL req_unexpected got=port%0d exp=none", req_port);
                end else begin
                    chk("req_port", req_port, exp_port.pop_front());
                end
            end
            if (req) req_hi_cnt++;
        end
        req_prev      = req;
        prev_stall    = tx_valid && !tx_ready;
        prev_vc       = {tx_valid, tx_char};
        lerr_prev     = link_err;
        prev_ctrl_acc = tx_valid && tx_ready && tx_char[8];
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc0;
        int rises0;
        logic [7:0] bnd[7];
        bnd = '{8'd0, 8'd8, 8'd9, 8'd31, 8'd32, 8'd254, 8'd255};
        reset    = 1'b0;
        link_err = 1'b0;
        tx_ready = 1'b0;

        repeat (3) @(negedge gclk);
        chk("rst_rx_ready", rx_ready, 1'b0);
        chk("rst_req", req, 1'b0);
        chk("rst_req_port", req_port, 5'd0);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_char", tx_char, 9'h000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_drop_cnt", drop_cnt, 8'd0);
        @(posedge gclk); #1;
        reset = 1'b1;
        repeat (2) @(negedge gclk);
        chk("rel_rx_ready", rx_ready, 1'b1);

        // Path-addressed packet, header deleted, grant after 3 cycles.
        @(posedge gclk); #1;
        tx_ready = 1'b1; gnt_delay = 3; tx_log.delete();
        pkt = '{9'h003, 9'h0AA, 9'h0BB, 9'h100};
        send_pkt();
        wait_idle();
        chk("path_port", last_port, 3);
        chk("path_len", tx_log.size(), 3);
        chk("path_c0", tx_log[0], 9'h0AA);
        chk("path_c2", tx_log[2], 9'h100);
        chk("path_drop", drop_cnt, 8'd0);

        // Logical address: header forwarded on LOG_PORT.
        @(posedge gclk); #1;
        gnt_delay = 1; tx_log.delete();
        pkt = '{9'h040, 9'h011, 9'h100};
        send_pkt();
        wait_idle();
        chk("log_port", last_port, 1);
        chk("log_c0", tx_log[0], 9'h040);
        chk("log_len", tx_log.size(), 3);

        // Invalid address discarded through EEP, then a normal packet.
        @(posedge gclk); #1;
        rises0 = req_rises;
        pkt = '{9'h01F, 9'h022, 9'h033, 9'h101};
        send_pkt();
        wait_idle();
        chk("inv_no_req", req_rises - rises0, 0);
        chk("inv_drop", drop_cnt, 8'd1);
        @(posedge gclk); #1;
        tx_log.delete();
        pkt = '{9'h002, 9'h055, 9'h100};
        send_pkt();
        wait_idle();
        chk("after_inv_port", last_port, 2);
        chk("after_inv_c0", tx_log[0], 9'h055);

        // Address boundaries: 0, PORTNUM, PORTNUM+1, 31, 32, 254, 255.
        for (int i = 0; i < 7; i++) begin
            @(posedge gclk); #1;
            pkt = '{{1'b0, bnd[i]}, 9'h05A, 9'h100};
            send_pkt();
            wait_idle();
        end
        chk("bnd_drop", drop_cnt, 8'd4);

        // Stray control chars in IDLE are eaten silently.
        @(posedge gclk); #1;
        rx_q.push_back(9'h100);
        rx_q.push_back(9'h101);
        pkt = '{9'h004, 9'h077, 9'h100};
        send_pkt();
        wait_idle();
        chk("stray_port", last_port, 4);
        chk("stray_drop", drop_cnt, 8'd4);

        // Fill under backpressure: header is deleted so DEPTH+1 chars get in before rx_ready drops.
        @(posedge gclk); #1;
        tx_ready = 1'b0; gnt_delay = 0; tx_log.delete(); acc0 = rx_acc_cnt;
        pkt.delete();
        pkt.push_back(9'h005);
        for (int i = 0; i < 18; i++) pkt.push_back(9'(128 + i));
        pkt.push_back(9'h100);
        send_pkt();
        repeat (40) @(negedge gclk);
        chk("fill_accepted", rx_acc_cnt - acc0, 17);
        chk("fill_rx_ready", rx_ready, 1'b0);
        chk("fill_backlog", rx_q.size(), 3);
        chk("fill_head", {tx_valid, tx_char}, {1'b1, 9'h080});
        @(posedge gclk); #1;
        tx_ready = 1'b1;
        wait_idle();
        chk("fill_len", tx_log.size(), 19);
        chk("fill_last_data", tx_log[17], 9'h091);
        chk("fill_eop", tx_log[18], 9'h100);

        // Link error mid-packet: buffered chars flushed, EEP inserted.
        @(posedge gclk); #1;
        gnt_delay = 1; tx_log.delete();
        pkt = '{9'h003, 9'h0AA};
        send_pkt();
        n = 0;
        while (tx_log.size() == 0 && n < 500) begin @(negedge gclk); n++; end
        chk("lerr_first", (tx_log.size() > 0) ? 32'(tx_log[0]) : 32'h0, 9'h0AA);
        @(posedge gclk); #1;
        tx_ready = 1'b0;
        rx_q.push_back(9'h0BB);
        rx_q.push_back(9'h0CC);
        repeat (6) @(posedge gclk);
        #1;
        link_err = 1'b1;
        exp_tx.delete();
        exp_tx.push_back(9'h101);
        @(negedge gclk);
        chk("lerr_stalled", {tx_valid, tx_char}, {1'b1, 9'h0BB});
        @(posedge gclk); #1;
        link_err = 1'b0;
        repeat (3) @(negedge gclk);
        chk("lerr_eep", {tx_valid, tx_char}, {1'b1, 9'h101});
        @(posedge gclk); #1;
        tx_ready = 1'b1;
        wait_idle();
        chk("lerr_len", tx_log.size(), 2);
        chk("lerr_busy", busy, 1'b0);
        chk("lerr_rx_ready", rx_ready, 1'b1);

`ifdef SPW_REQ_TIMEOUT_EN
        // Grant withheld: 8 cycles in REQ (req is visible for the last 7), then discard.
        @(posedge gclk); #1;
        gnt_en = 1'b0; req_hi_cnt = 0;
        pkt = '{9'h003, 9'h011, 9'h022, 9'h100};
        send_pkt();
        exp_tx.delete();
        drop_exp = drop_exp + 1;
        wait_idle();
        chk("to_req_cycles", req_hi_cnt, TO - 1);
        chk("to_drop", drop_cnt, 8'd5);
        gnt_en = 1'b1;
`endif

        // Saturation of the discard counter.
        @(posedge gclk); #1;
        for (int i = 0; i < 255; i++) begin
            pkt = '{9'h00F, 9'h100};
            send_pkt();
        end
        wait_idle();
        chk("drop_sat", drop_cnt, 8'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
